// File: rtl/trng_pkg.sv
// Shared types, default thresholds and helpers for the TRNG health buffer.
package trng_pkg;

  localparam int TRNG_WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    CHECK = 2'd2,
    FAIL  = 2'd3
  } state_e;

  localparam int DEF_DEPTH         = 4;
  localparam int DEF_RCT_CUTOFF    = 3;
  localparam int DEF_APT_WINDOW    = 16;
  localparam int DEF_APT_LO        = 192;
  localparam int DEF_APT_HI        = 320;
  localparam int DEF_STARTUP_WORDS = 16;

  // Number of set bits in a TRNG word (0..32).
  function automatic logic [5:0] popcount32(input logic [TRNG_WORD_W-1:0] w);
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < TRNG_WORD_W; i++) begin
      c = c + {5'd0, w[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/trng_health_buffer_if.sv
// TRNG request/ready handshake plus the valid/ready entropy stream.
// master = the health buffer, slave = its environment (TRNG and consumer).
interface trng_health_buffer_if;
  import trng_pkg::*;

  logic                   trng_request;
  logic                   trng_ready;
  logic [TRNG_WORD_W-1:0] trng_random_number;
  logic                   rnd_valid;
  logic                   rnd_ready;
  logic [TRNG_WORD_W-1:0] rnd_data;

  modport master (
    output trng_request, rnd_valid, rnd_data,
    input  trng_ready, trng_random_number, rnd_ready
  );

  modport slave (
    input  trng_request, rnd_valid, rnd_data,
    output trng_ready, trng_random_number, rnd_ready
  );

endinterface

// File: rtl/rng_sync_fifo.sv
// Small synchronous first-word-fall-through FIFO. Flush wins over push/pop;
// the head reads as zero while the FIFO is empty.
module rng_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [WIDTH-1:0]             din,
  input  logic                         pop,
  input  logic                         flush,
  output logic [WIDTH-1:0]             dout,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  assign do_push = push && !flush;
  assign do_pop  = pop && !flush && (count_q != '0);

  // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is a power of two).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Word storage; contents are only observed through count-qualified dout.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign count = count_q;

endmodule

// File: rtl/trng_health_buffer.sv
// Requests words from the TRNG, runs stuck / repetition-count / adaptive
// proportion health tests on each one, discards the startup words and buffers
// the rest for downstream crypto cores. Any failure latches a sticky alarm.
module trng_health_buffer
  import trng_pkg::*;
#(
  parameter int DEPTH         = DEF_DEPTH,
  parameter int RCT_CUTOFF    = DEF_RCT_CUTOFF,
  parameter int APT_WINDOW    = DEF_APT_WINDOW,
  parameter int APT_LO        = DEF_APT_LO,
  parameter int APT_HI        = DEF_APT_HI,
  parameter int STARTUP_WORDS = DEF_STARTUP_WORDS
) (
  input  logic                       clk,
  input  logic                       rst,
  trng_health_buffer_if.master       bus,
  output logic                       health_fail,
  input  logic                       health_clr,
  output logic                       startup_done,
  output logic [$clog2(DEPTH+1)-1:0] fill_level
);

  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int SUM_W = $clog2(32*APT_WINDOW+1);
  localparam int IDX_W = $clog2(APT_WINDOW);
  localparam int RCT_W = $clog2(RCT_CUTOFF+1);
  localparam int SU_W  = $clog2(STARTUP_WORDS+1);

  state_e                 state_q, state_d;
  logic [TRNG_WORD_W-1:0] cap_word_q, cap_word_d;
  logic [TRNG_WORD_W-1:0] prev_word_q, prev_word_d;
  logic [RCT_W-1:0]       rct_cnt_q, rct_cnt_d;
  logic [SUM_W-1:0]       apt_sum_q, apt_sum_d;
  logic [IDX_W-1:0]       apt_idx_q, apt_idx_d;
  logic [SU_W-1:0]        su_cnt_q, su_cnt_d;
  logic                   su_done_q, su_done_d;
  logic                   req_q, req_d;
  logic                   fail_q, fail_d;

  logic [5:0]             pop_cnt;
  logic [RCT_W-1:0]       rct_next;
  logic [SUM_W-1:0]       apt_total;
  logic                   apt_last, word_fail;
  logic                   fifo_push, fifo_flush, fifo_pop;
  logic [TRNG_WORD_W-1:0] fifo_dout;

  // Health test evaluation on the captured word.
  assign pop_cnt   = popcount32(cap_word_q);
  assign rct_next  = (cap_word_q == prev_word_q) ? rct_cnt_q + RCT_W'(1) : RCT_W'(1);
  assign apt_total = apt_sum_q + SUM_W'(pop_cnt);
  assign apt_last  = (apt_idx_q == IDX_W'(APT_WINDOW-1));
  assign word_fail = (cap_word_q == '0) || (cap_word_q == '1)
                  || (rct_next >= RCT_W'(RCT_CUTOFF))
                  || (apt_last && ((apt_total < SUM_W'(APT_LO)) || (apt_total > SUM_W'(APT_HI))));

  // Next-state, test counter updates and FIFO control; health_clr overrides everything.
  always_comb begin
    state_d     = state_q;
    cap_word_d  = cap_word_q;
    prev_word_d = prev_word_q;
    rct_cnt_d   = rct_cnt_q;
    apt_sum_d   = apt_sum_q;
    apt_idx_d   = apt_idx_q;
    su_cnt_d    = su_cnt_q;
    su_done_d   = su_done_q;
    fifo_push   = 1'b0;
    fifo_flush  = (state_q == FAIL);
    case (state_q)
      IDLE: if (fill_level < CNT_W'(DEPTH)) state_d = REQ;
      REQ: begin
        if (bus.trng_ready) begin
          cap_word_d = bus.trng_random_number;
          state_d    = CHECK;
        end
      end
      CHECK: begin
        if (word_fail) begin
          state_d    = FAIL;
          fifo_flush = 1'b1;
        end else begin
          state_d     = IDLE;
          prev_word_d = cap_word_q;
          rct_cnt_d   = rct_next;
          apt_sum_d   = apt_last ? '0 : apt_total;
          apt_idx_d   = apt_last ? '0 : apt_idx_q + IDX_W'(1);
          if (su_done_q) begin
            fifo_push = 1'b1;
          end else begin
            su_cnt_d = su_cnt_q + SU_W'(1);
            if (su_cnt_q == SU_W'(STARTUP_WORDS-1)) su_done_d = 1'b1;
          end
        end
      end
      FAIL: ;
      default: state_d = IDLE;
    endcase
    if (health_clr) begin
      state_d     = IDLE;
      fifo_flush  = 1'b1;
      fifo_push   = 1'b0;
      prev_word_d = '0;
      rct_cnt_d   = RCT_W'(1);
      apt_sum_d   = '0;
      apt_idx_d   = '0;
      su_cnt_d    = '0;
      su_done_d   = 1'b0;
    end
    req_d  = (state_d == REQ);
    fail_d = (state_d == FAIL);
  end

  // State, captured words, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cap_word_q  <= '0;
      prev_word_q <= '0;
      rct_cnt_q   <= RCT_W'(1);
      apt_sum_q   <= '0;
      apt_idx_q   <= '0;
      su_cnt_q    <= '0;
      su_done_q   <= 1'b0;
      req_q       <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cap_word_q  <= cap_word_d;
      prev_word_q <= prev_word_d;
      rct_cnt_q   <= rct_cnt_d;
      apt_sum_q   <= apt_sum_d;
      apt_idx_q   <= apt_idx_d;
      su_cnt_q    <= su_cnt_d;
      su_done_q   <= su_done_d;
      req_q       <= req_d;
      fail_q      <= fail_d;
    end
  end

  assign fifo_pop = bus.rnd_valid && bus.rnd_ready;

  rng_sync_fifo #(
    .WIDTH (TRNG_WORD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .din   (cap_word_q),
    .pop   (fifo_pop),
    .flush (fifo_flush),
    .dout  (fifo_dout),
    .count (fill_level)
  );

  assign bus.trng_request = req_q;
  assign bus.rnd_valid    = (fill_level != '0);
  assign bus.rnd_data     = fifo_dout;
  assign health_fail      = fail_q;
  assign startup_done     = su_done_q;

endmodule

// File: doc/trng_health_buffer.md
# trng_health_buffer

Downstream consumer of the ring-oscillator TRNG. It requests 32-bit words over the TRNG's level request/ready handshake and runs continuous health tests on every word. Words that pass go into a small FIFO, which feeds crypto cores through a valid/ready stream. On any health failure it stops sourcing entropy and holds a sticky alarm until software clears it.

## Interface
Parameters:
- DEPTH, 4: FIFO depth in 32-bit words, power of two, ≥2.
- RCT_CUTOFF, 3: number of consecutive identical words that triggers a repetition-count failure.
- APT_WINDOW, 16: words per adaptive-proportion window.
- APT_LO, 192: minimum total ones per window, inclusive.
- APT_HI, 320: maximum total ones per window, inclusive.
- STARTUP_WORDS, 16: number of words tested and then discarded after reset or clear.

Ports:
- clk  in  1  single clock; the block has one clock.
- rst  in  1  reset, asynchronous, active-high. At top level it is driven from ~rst_n.
- trng_request  out  1  request to the TRNG, registered.
- trng_ready  in  1  TRNG word available.
- trng_random_number  in  32  TRNG word; valid while trng_ready is high.
- rnd_valid  out  1  FIFO head valid.
- rnd_ready  in  1  consumer accepts the head word.
- rnd_data  out  32  FIFO head word.
- health_fail  out  1  sticky health alarm.
- health_clr  in  1  single-cycle pulse; clears the alarm and restarts startup.
- startup_done  out  1  high once STARTUP_WORDS words have passed.
- fill_level  out  $clog2(DEPTH+1)  current FIFO occupancy.

## Operation
- FSM states: IDLE, REQ, CHECK, FAIL. trng_request = (state==REQ), registered.
- IDLE → REQ when fill_level < DEPTH. Otherwise the FSM stays in IDLE.
- REQ: wait for trng_ready. When it is seen, capture trng_random_number into cap_word and go to CHECK.
- CHECK: evaluate all tests on cap_word.
  - Pass: go to IDLE. Push cap_word if startup_done; otherwise increment the startup count.
  - Fail: go to FAIL.
- Request protocol: request is low in CHECK and IDLE, so it stays low for ≥2 cycles between words. This lets the TRNG drop ready and reset its bit counter.
- Stuck test: cap_word == 32'h0 or 32'hFFFFFFFF is a failure.
- Repetition count test (RCT):
  - rct_cnt resets to 1.
  - If cap_word equals prev_word, rct_cnt increments; otherwise it is set to 1.
  - The test fails when rct_cnt reaches RCT_CUTOFF.
  - prev_word updates on every word, including discarded startup words.
- Adaptive proportion test (APT):
  - apt_sum accumulates popcount(cap_word); width is $clog2(32*APT_WINDOW+1).
  - apt_idx counts words 0..APT_WINDOW-1.
  - On the last word of a window, the test checks (apt_sum + popcount) ∈ [APT_LO, APT_HI]. Out of range is a failure.
  - apt_sum and apt_idx then reset for the next window.
- FAIL state:
  - health_fail=1, trng_request=0, FIFO flushed (fill_level=0, rnd_valid=0).
  - All test counters frozen.
  - Exits only on health_clr: go to IDLE, reset rct_cnt/apt_sum/apt_idx/startup count, startup_done=0, prev_word=0.
- health_clr outside FAIL: same counter/startup restart, and the FIFO is flushed. Any in-flight REQ returns to IDLE.
- FIFO: first-word fall-through from registered storage. Pop when rnd_valid && rnd_ready.
  - Push and pop in the same cycle leave fill_level unchanged.
  - Push only happens in CHECK. REQ is entered only when not full, and occupancy cannot rise between REQ and CHECK, so overflow is impossible by construction.

## Timing
- Reset values: trng_request=0, rnd_valid=0, rnd_data=0, health_fail=0, startup_done=0, fill_level=0. State=IDLE; cap_word, prev_word and all counters are 0, except rct_cnt=1.
- REQ is entered on the first edge after rst deasserts.
- Capture edge E is the edge where REQ sees trng_ready=1.
  - CHECK occupies the cycle after E.
  - Push happens at edge E+1; rnd_valid and fill_level update in the cycle after E+1.
- Failure detected in CHECK: health_fail=1 and rnd_valid=0 from edge E+1.
- Minimum word period: TRNG fill time + 3 cycles (REQ-ready, CHECK, IDLE).
- startup_done rises at the CHECK edge of the STARTUP_WORDS-th passing word. That word is discarded; the next passing word is the first one pushed.
- rst asserted mid-operation returns all state to reset values immediately (asynchronous), including a mid-REQ request.

## Structure
- Package trng_pkg:
  - TRNG_WORD_W = 32.
  - State enum {IDLE, REQ, CHECK, FAIL}.
  - Default threshold constants.
  - popcount32 function.
- One sub-module: rng_sync_fifo, parameterised by WIDTH and DEPTH, with push, pop, flush, dout, count and ports clk/rst. Health FSM and test counters stay in trng_health_buffer.

## Test plan
- Reset, TRNG model returns distinct balanced words (popcount 16), rnd_ready=1 → first 16 words discarded, startup_done=1; word 17 appears on rnd_data 2 cycles after its capture; health_fail stays 0.
- After startup, rnd_ready=0 → fill_level reaches 4 and trng_request stays 0. One rnd_ready pulse → fill_level=3, then a new request is issued.
- Model returns 32'hA5A5A5A5 three times in a row → health_fail=1 at the third word's CHECK edge, FIFO flushed, trng_request held 0.
- 16-word window with each word popcount 8 (sum 128 < 192) → APT failure on the 16th word. Repeat with popcount 24 (sum 384 > 320) → failure.
- Model returns 32'h00000000 once → immediate failure. health_clr pulse → state IDLE, startup_done=0, requests resume, 16 words discarded again.
- rst asserted while trng_request=1 and fill_level=2 → all outputs return to reset values on the same cycle. After release, operation restarts from the startup phase.
